// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-address width, the zero register,
// MDU state encoding and default MDU latencies.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // $0 is hardwired, so a write to it can never be a real dependency.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks the busy window of the multi-cycle mult/div unit with a down-counter.
//   state | meaning
//   IDLE  | no MDU op in flight, MDUStart accepted
//   BUSY  | op in flight, mdu_cnt = busy cycles remaining including this one
module mdu_busy_tracker
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic MDUStart,
  input  logic MDUIsDiv,
  output logic MDUBusy,
  output logic MDUDone
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  mdu_state_t    state, state_nxt;
  logic [CW-1:0] mdu_cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MDU_IDLE;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= cnt_nxt;
    end
  end

  // A start while BUSY is dropped; the hazard logic keeps MDU ops out of EX then.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = mdu_cnt;
    case (state)
      MDU_IDLE: begin
        if (MDUStart) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = MDUIsDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      MDU_BUSY: begin
        cnt_nxt = mdu_cnt - CW'(1);
        if (mdu_cnt == CW'(1)) state_nxt = MDU_IDLE;
      end
      default: begin
        state_nxt = MDU_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    MDUBusy = 1'b0;
    MDUDone = 1'b0;
    if (!rst && state == MDU_BUSY) begin
      MDUBusy = 1'b1;
      MDUDone = (mdu_cnt == CW'(1));
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detection: stalls PC/IFID and bubbles IDEX on hazards the
// forwarding unit cannot cover, squashes IFID on taken branches, counts stalls.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] IFIDRs,
  input  logic [REG_ADDR_W-1:0] IFIDRt,
  input  logic                  IFIDIsBranch,
  input  logic                  IFIDIsMDU,
  input  logic                  IFIDHiLo,
  input  logic                  BranchTaken,
  input  logic                  IDEXMemRead,
  input  logic                  IDEXRegWrite,
  input  logic [REG_ADDR_W-1:0] IDEXRd,
  input  logic                  EXMEMMemRead,
  input  logic [REG_ADDR_W-1:0] EXMEMRd,
  input  logic                  MDUStart,
  input  logic                  MDUIsDiv,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IDEXBubble,
  output logic                  IFIDFlush,
  output logic                  MDUBusy,
  output logic                  MDUDone,
  output logic [CNT_W-1:0]      StallCount
);

  logic idex_hit, exmem_hit;
  logic load_use, br_alu, br_load, mdu_haz, stall;

  mdu_busy_tracker #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .MDUStart(MDUStart),
    .MDUIsDiv(MDUIsDiv),
    .MDUBusy (MDUBusy),
    .MDUDone (MDUDone)
  );

  // Branches resolve in ID, so any in-flight producer of a compare operand
  // stalls; a load two ahead costs a second cycle.
  always_comb begin
    idex_hit  = reg_match(IDEXRd, IFIDRs)  | reg_match(IDEXRd, IFIDRt);
    exmem_hit = reg_match(EXMEMRd, IFIDRs) | reg_match(EXMEMRd, IFIDRt);
    load_use  = IDEXMemRead & idex_hit;
    br_alu    = IFIDIsBranch & IDEXRegWrite & idex_hit;
    br_load   = IFIDIsBranch & EXMEMMemRead & exmem_hit;
    mdu_haz   = MDUBusy & (IFIDHiLo | IFIDIsMDU);
    stall     = !rst & (load_use | br_alu | br_load | mdu_haz);
  end

  always_comb begin
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXBubble = stall;
    IFIDFlush  = !rst & BranchTaken & IFIDIsBranch & !stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (!PCWrite && !(&StallCount)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a vector table for the
// combinational hazard terms plus hand-written multi-cycle sequences.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IFIDRs, IFIDRt, IDEXRd, EXMEMRd;
  logic        IFIDIsBranch, IFIDIsMDU, IFIDHiLo, BranchTaken;
  logic        IDEXMemRead, IDEXRegWrite, EXMEMMemRead;
  logic        MDUStart, MDUIsDiv;
  logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDUBusy, MDUDone;
  logic [15:0] StallCount;

  int n_cmp = 0;
  int n_bad = 0;
  int sc_model = 0;

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .rst(rst),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt),
    .IFIDIsBranch(IFIDIsBranch), .IFIDIsMDU(IFIDIsMDU), .IFIDHiLo(IFIDHiLo),
    .BranchTaken(BranchTaken),
    .IDEXMemRead(IDEXMemRead), .IDEXRegWrite(IDEXRegWrite), .IDEXRd(IDEXRd),
    .EXMEMMemRead(EXMEMMemRead), .EXMEMRd(EXMEMRd),
    .MDUStart(MDUStart), .MDUIsDiv(MDUIsDiv),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFIDFlush(IFIDFlush), .MDUBusy(MDUBusy), .MDUDone(MDUDone),
    .StallCount(StallCount)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       isbr, ismdu, hilo, taken;
    logic       idex_mr, idex_rw;
    logic [4:0] idex_rd;
    logic       exmem_mr;
    logic [4:0] exmem_rd;
    logic       exp_stall, exp_flush;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    IFIDRs = 0; IFIDRt = 0; IDEXRd = 0; EXMEMRd = 0;
    IFIDIsBranch = 0; IFIDIsMDU = 0; IFIDHiLo = 0; BranchTaken = 0;
    IDEXMemRead = 0; IDEXRegWrite = 0; EXMEMMemRead = 0;
    MDUStart = 0; MDUIsDiv = 0;
  endtask

  task automatic chk_ctrl(input string name, input logic stall, input logic flush);
    chk({name, ".PCWrite"},    PCWrite,    !stall);
    chk({name, ".IFIDWrite"},  IFIDWrite,  !stall);
    chk({name, ".IDEXBubble"}, IDEXBubble, stall);
    chk({name, ".IFIDFlush"},  IFIDFlush,  flush);
  endtask

  // Advance one clock, updating the stall-count model, and leave time just past the edge.
  task automatic tick(input logic stall_exp);
    @(posedge clk);
    if (rst) sc_model = 0;
    else if (stall_exp && sc_model < 65535) sc_model++;
    #1;
  endtask

  task automatic load_use_inputs();
    clear_inputs();
    IFIDRs = 5'd2; IFIDRt = 5'd4;
    IDEXMemRead = 1; IDEXRegWrite = 1; IDEXRd = 5'd2;
  endtask

  task automatic do_reset();
    rst = 1;
    load_use_inputs();
    IFIDIsBranch = 1; BranchTaken = 1; IFIDHiLo = 1; MDUStart = 1;
    @(negedge clk);
    chk_ctrl("reset", 1'b0, 1'b0);
    chk("reset.MDUBusy", MDUBusy, 0);
    tick(1'b0);
    tick(1'b0);
    chk("reset.StallCount", StallCount, 0);
    chk("reset.MDUDone", MDUDone, 0);
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    do_reset();

    //          rs  rt  br mdu hl tk imr irw ird emr erd  stall flush
    vecs[0]  = '{0,  0,  0, 0, 0, 0, 0,  0,  0,  0,  0,   0,   0};
    vecs[1]  = '{2,  4,  0, 0, 0, 0, 1,  1,  2,  0,  0,   1,   0};
    vecs[2]  = '{4,  2,  0, 0, 0, 0, 1,  1,  2,  0,  0,   1,   0};
    vecs[3]  = '{0,  3,  0, 0, 0, 0, 1,  1,  0,  0,  0,   0,   0};
    vecs[4]  = '{2,  4,  0, 0, 0, 0, 1,  1,  7,  0,  0,   0,   0};
    vecs[5]  = '{5,  0,  1, 0, 0, 1, 0,  1,  5,  0,  0,   1,   0};
    vecs[6]  = '{5,  0,  0, 0, 0, 0, 0,  1,  5,  0,  0,   0,   0};
    vecs[7]  = '{0,  5,  1, 0, 0, 1, 0,  0,  0,  1,  5,   1,   0};
    vecs[8]  = '{1,  2,  1, 0, 0, 1, 0,  0,  0,  0,  0,   0,   1};
    vecs[9]  = '{1,  2,  1, 0, 0, 0, 0,  0,  0,  0,  0,   0,   0};
    vecs[10] = '{0,  0,  1, 0, 0, 1, 0,  1,  0,  1,  0,   0,   1};
    vecs[11] = '{5,  1,  1, 0, 0, 1, 0,  0,  0,  0,  5,   0,   1};
    vecs[12] = '{3,  0,  0, 1, 1, 0, 0,  0,  0,  0,  0,   0,   0};
    vecs[13] = '{6,  9,  1, 0, 0, 0, 0,  1,  9,  0,  0,   1,   0};

    for (int i = 0; i < 14; i++) begin
      clear_inputs();
      IFIDRs = vecs[i].rs; IFIDRt = vecs[i].rt;
      IFIDIsBranch = vecs[i].isbr; IFIDIsMDU = vecs[i].ismdu;
      IFIDHiLo = vecs[i].hilo; BranchTaken = vecs[i].taken;
      IDEXMemRead = vecs[i].idex_mr; IDEXRegWrite = vecs[i].idex_rw;
      IDEXRd = vecs[i].idex_rd;
      EXMEMMemRead = vecs[i].exmem_mr; EXMEMRd = vecs[i].exmem_rd;
      @(negedge clk);
      chk_ctrl($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush);
      tick(vecs[i].exp_stall);
      chk($sformatf("vec%0d.StallCount", i), StallCount, sc_model);
    end

    // lw $5 then beq $5,$0 (taken): BrALU, then BrLoad, then flush.
    clear_inputs();
    IFIDIsBranch = 1; BranchTaken = 1; IFIDRs = 5; IFIDRt = 0;
    IDEXMemRead = 1; IDEXRegWrite = 1; IDEXRd = 5;
    @(negedge clk); chk_ctrl("lwbr.c1", 1'b1, 1'b0);
    tick(1'b1);
    IDEXMemRead = 0; IDEXRegWrite = 0; IDEXRd = 0;
    EXMEMMemRead = 1; EXMEMRd = 5;
    @(negedge clk); chk_ctrl("lwbr.c2", 1'b1, 1'b0);
    tick(1'b1);
    EXMEMMemRead = 0; EXMEMRd = 0;
    @(negedge clk); chk_ctrl("lwbr.c3", 1'b0, 1'b1);
    tick(1'b0);
    chk("lwbr.StallCount", StallCount, sc_model);
    clear_inputs();

    // mult: busy exactly 4 cycles, done on the 4th.
    MDUStart = 1; MDUIsDiv = 0;
    @(negedge clk); chk("mult.busy0", MDUBusy, 0);
    tick(1'b0);
    MDUStart = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("mult.busy%0d", i), MDUBusy, 1);
      chk($sformatf("mult.done%0d", i), MDUDone, (i == 4));
      tick(1'b0);
    end
    @(negedge clk); chk("mult.busy5", MDUBusy, 0);

    // div with mflo queued in ID: 32 stall cycles, issues on cycle 33.
    tick(1'b0);
    MDUStart = 1; MDUIsDiv = 1;
    tick(1'b0);
    MDUStart = 0; MDUIsDiv = 0; IFIDHiLo = 1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk($sformatf("div.busy%0d", i), MDUBusy, 1);
      chk($sformatf("div.done%0d", i), MDUDone, (i == 32));
      chk($sformatf("div.pcw%0d", i), PCWrite, 0);
      tick(1'b1);
    end
    @(negedge clk);
    chk("div.busy33", MDUBusy, 0);
    chk_ctrl("div.issue33", 1'b0, 1'b0);
    chk("div.StallCount", StallCount, sc_model);
    tick(1'b0);
    clear_inputs();

    // Reset on cycle 10 of a div: mflo issues right after.
    MDUStart = 1; MDUIsDiv = 1;
    tick(1'b0);
    MDUStart = 0; MDUIsDiv = 0; IFIDHiLo = 1;
    for (int i = 1; i < 10; i++) tick(1'b1);
    rst = 1;
    @(negedge clk);
    chk("rstdiv.busy_in_rst", MDUBusy, 0);
    chk("rstdiv.pcw_in_rst", PCWrite, 1);
    tick(1'b0);
    rst = 0;
    @(negedge clk);
    chk("rstdiv.busy", MDUBusy, 0);
    chk("rstdiv.StallCount", StallCount, 0);
    chk_ctrl("rstdiv.issue", 1'b0, 1'b0);
    tick(1'b0);
    clear_inputs();

    // Saturation: force a long load-use stall.
    load_use_inputs();
    for (int i = 1; i <= 65540; i++) begin
      tick(1'b1);
      if (i == 65534 || i == 65535 || i == 65540)
        chk($sformatf("sat.%0d", i), StallCount, sc_model);
    end
    chk("sat.final", StallCount, 16'hFFFF);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
